// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2
  } arb_state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Ownership state belonging to a requester id.
  function automatic arb_state_e own_state(input logic id);
    return (id == PORT1) ? S_OWN1 : S_OWN0;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rd_tag_pipe.sv
// MEM_LAT-deep shift register carrying {valid,id} of issued reads so the
// returning memory data can be steered to the requester that asked for it.
module dmem_arbiter_rd_tag_pipe #(
  parameter int MEM_LAT = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic push_valid,
  input  logic push_id,
  output logic pop_valid,
  output logic pop_id
);

  logic [MEM_LAT-1:0] vld_p;
  logic [MEM_LAT-1:0] id_p;

  // Valid bits are control and are cleared by reset, dropping in-flight reads.
  always_ff @(posedge clock) begin
    if (!reset) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= push_valid;
      for (int i = 1; i < MEM_LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  // Tag ids only matter where their valid bit is set, so they shift freely.
  always_ff @(posedge clock) begin
    id_p[0] <= push_id;
    for (int i = 1; i < MEM_LAT; i++) begin
      id_p[i] <= id_p[i-1];
    end
  end

  assign pop_valid = vld_p[MEM_LAT-1];
  assign pop_id    = id_p[MEM_LAT-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the core
// (port 0) and the DMA/loader (port 1), with a bounded burst per ownership.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 4,
  parameter int MEM_LAT   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memDataOut,
  output logic              memWe,
  input  logic [DATA_W-1:0] memDataIn
);

  localparam int              CNT_W    = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             last_owner, last_owner_nxt;

  logic own_id, own_req, oth_req, rel;
  logic push_valid, pop_valid, pop_id;

  // Grants are gated by reset so nothing leaks out while reset is held.
  assign gnt0 = reset && (state == S_OWN0) && req0;
  assign gnt1 = reset && (state == S_OWN1) && req1;

  // Ownership state, burst count and tie-break history.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      last_owner <= PORT1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last_owner <= last_owner_nxt;
    end
  end

  // Next ownership: release on owner dropping req or on its last burst beat.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    last_owner_nxt = last_owner;
    own_id         = (state == S_OWN1);
    own_req        = own_id ? req1 : req0;
    oth_req        = own_id ? req0 : req1;
    rel            = !own_req || (cnt == CNT_LAST);
    case (state)
      S_IDLE: begin
        if (req0 && req1) state_nxt = own_state(!last_owner);
        else if (req0)    state_nxt = S_OWN0;
        else if (req1)    state_nxt = S_OWN1;
      end
      S_OWN0, S_OWN1: begin
        if (rel) begin
          last_owner_nxt = own_id;
          cnt_nxt        = '0;
          if (oth_req)      state_nxt = own_state(!own_id);
          else if (own_req) state_nxt = state;
          else              state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Memory side follows the granted requester; idle bus drives zeros.
  always_comb begin
    memAddr    = '0;
    memDataOut = '0;
    memWe      = 1'b0;
    if (gnt0) begin
      memAddr    = addr0;
      memDataOut = wdata0;
      memWe      = we0;
    end else if (gnt1) begin
      memAddr    = addr1;
      memDataOut = wdata1;
      memWe      = we1;
    end
  end

  assign push_valid = (gnt0 || gnt1) && !memWe;

  dmem_arbiter_rd_tag_pipe #(
    .MEM_LAT(MEM_LAT)
  ) u_rd_tag_pipe (
    .clock     (clock),
    .reset     (reset),
    .push_valid(push_valid),
    .push_id   (gnt1),
    .pop_valid (pop_valid),
    .pop_id    (pop_id)
  );

  assign rvalid0 = reset && pop_valid && (pop_id == PORT0);
  assign rvalid1 = reset && pop_valid && (pop_id == PORT1);
  assign rdata0  = rvalid0 ? memDataIn : '0;
  assign rdata1  = rvalid1 ? memDataIn : '0;

endmodule
